test_monitor: RTL and testbench
===============================

TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, cycles allowed in RUN before timeout; 0 disables timeout.
REQ-002 SHALL have parameter DONE_REG, default 26, register index whose nonzero write ends the test.
REQ-003 SHALL have parameter RESULT_REG, default 27, register index holding the result (1 = pass).
REQ-004 SHALL have parameter CODE_REG, default 3, register index holding the test number reported on failure.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wb_we  input  1  the core's register-file writeback strobe.
REQ-008 SHALL have port wb_addr  input  5  writeback destination register index.
REQ-009 SHALL have port wb_data  input  32  writeback data.
REQ-010 SHALL have port done  output  1  test has ended (pass, fail or timeout).
REQ-011 SHALL have port pass  output  1  test ended with result register == 1.
REQ-012 SHALL have port fail  output  1  test ended with result register != 1.
REQ-013 SHALL have port timeout  output  1  watchdog expired before the done write.
REQ-014 SHALL have port fail_code  output  32  CODE_REG shadow value frozen at end of test.
REQ-015 SHALL have port cycle_cnt  output  32  cycles spent in RUN.
REQ-016 SHALL have port wr_cnt  output  32  qualifying writebacks counted in RUN.

Function
REQ-017 SHALL implement the states RUN, PASS, FAIL and TIMEOUT, entering RUN on reset.
REQ-018 SHALL treat PASS, FAIL and TIMEOUT as terminal, holding them and all outputs until rst.
REQ-019 SHALL count a qualifying write as wb_we=1 with wb_addr!=0; writes to x0 SHALL be ignored entirely.
REQ-020 SHALL, on a qualifying write to RESULT_REG or CODE_REG in RUN, update the corresponding 32-bit shadow register.
REQ-021 SHALL, on a qualifying write to DONE_REG with wb_data!=0 in RUN, go to PASS if the RESULT_REG shadow == 1, else FAIL.
REQ-022 SHALL ignore a write of zero to DONE_REG, remaining in RUN.
REQ-023 SHALL evaluate pass/fail with the shadow value as held before the done-write edge, since the done write is a separate register.
REQ-024 SHALL assert done/pass/fail/timeout in the cycle after the edge that sampled the terminating condition (latency 1).
REQ-025 SHALL keep done = pass | fail | timeout, with pass, fail and timeout mutually exclusive.
REQ-026 SHALL increment cycle_cnt every cycle in RUN, freeze it in terminal states, and saturate it at 0xFFFFFFFF without wrap.
REQ-027 SHALL increment wr_cnt per qualifying write in RUN, including the terminating write, and saturate it at 0xFFFFFFFF.
REQ-028 SHALL, when TIMEOUT_CYCLES != 0, go to TIMEOUT at the edge where cycle_cnt == TIMEOUT_CYCLES-1 and no done write occurs.
REQ-029 SHALL give the done write priority over the timeout when both occur at the same edge.
REQ-030 SHALL load fail_code from the CODE_REG shadow on entering FAIL or TIMEOUT, and hold fail_code at 0 on PASS.
REQ-031 SHALL take no action on writes occurring in terminal states: no shadow updates and no counting.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, enter RUN and clear done, pass, fail, timeout, fail_code, cycle_cnt, wr_cnt and both shadows to 0.
REQ-033 SHALL give reset priority over any simultaneous writeback, which is dropped.
REQ-034 SHALL let reset asserted mid-test or in a terminal state restart monitoring from RUN with cleared counters.
REQ-035 SHALL be purely synchronous: with no clock edge, no output changes, whatever rst does.

Verification
REQ-036 Pass: write x27=1, then x26=1 at cycle 10 -> pass=1, done=1 next cycle; fail_code=0; wr_cnt=2.
REQ-037 Fail: write x3=5, x27=0, then x26=1 -> fail=1 next cycle; fail_code=5; pass=0.
REQ-038 Timeout: TIMEOUT_CYCLES=20, no done write -> timeout=1 after exactly 20 RUN cycles; cycle_cnt=20.
REQ-039 Race: TIMEOUT_CYCLES=20, x27=1 set, x26=1 written at the 20th RUN cycle -> pass=1, timeout=0.
REQ-040 Filtering: writes to x0 of any data and x26=0 -> no termination and wr_cnt excludes x0 writes; a later write in PASS -> wr_cnt unchanged.
REQ-041 Reset mid-test: rst=1 for one cycle after x27=1 -> shadows, counters and outputs 0; a following x26=1 alone -> fail=1, fail_code=0.

Source files
------------

// File: rtl/test_monitor.sv
// test_monitor: watches a core's register-file writeback port and decides the
// outcome of a self-checking test program. A nonzero write to DONE_REG ends the
// test; the previously written RESULT_REG value selects pass or fail, and a
// watchdog ends a test that never signals done.
module test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned RESULT_REG     = 27,
  parameter int unsigned CODE_REG       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] fail_code,
  output logic [31:0] cycle_cnt,
  output logic [31:0] wr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [4:0]  DONE_A   = 5'(DONE_REG);
  localparam logic [4:0]  RESULT_A = 5'(RESULT_REG);
  localparam logic [4:0]  CODE_A   = 5'(CODE_REG);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic [31:0] result_sh;
  logic [31:0] code_sh;

  // Writes to x0 are architecturally discarded, so they never qualify.
  logic qual_wr;
  logic done_wr;
  logic to_hit;

  // Decode the terminating conditions seen at this edge.
  always_comb begin
    qual_wr = wb_we && (wb_addr != 5'd0);
    done_wr = qual_wr && (wb_addr == DONE_A) && (wb_data != 32'd0);
    to_hit  = TO_EN && (cycle_cnt == TO_LAST);
  end

  // Monitor FSM, shadows and counters; terminal states freeze everything.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values; that is what makes the done write see the old result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= 32'd0;
      cycle_cnt <= 32'd0;
      wr_cnt    <= 32'd0;
      result_sh <= 32'd0;
      code_sh   <= 32'd0;
    end else if (state == ST_RUN) begin
      if (cycle_cnt != 32'hFFFF_FFFF)
        cycle_cnt <= cycle_cnt + 32'd1;

      if (qual_wr) begin
        if (wr_cnt != 32'hFFFF_FFFF)
          wr_cnt <= wr_cnt + 32'd1;
        if (wb_addr == RESULT_A)
          result_sh <= wb_data;
        if (wb_addr == CODE_A)
          code_sh <= wb_data;
      end

      // The done write wins over a watchdog expiry on the same edge.
      if (done_wr) begin
        done <= 1'b1;
        if (result_sh == 32'd1) begin
          state <= ST_PASS;
          pass  <= 1'b1;
        end else begin
          state     <= ST_FAIL;
          fail      <= 1'b1;
          fail_code <= code_sh;
        end
      end else if (to_hit) begin
        state     <= ST_TIMEOUT;
        done      <= 1'b1;
        timeout   <= 1'b1;
        fail_code <= code_sh;
      end
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Directed testbench for test_monitor: a cycle-by-cycle vector table followed
// by hand-written sequences for pass timing, watchdog expiry and the
// done-versus-timeout race.
module tb_test_monitor;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_code, cycle_cnt, wr_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  test_monitor #(
    .TIMEOUT_CYCLES(TO),
    .DONE_REG      (26),
    .RESULT_REG    (27),
    .CODE_REG      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .fail_code(fail_code),
    .cycle_cnt(cycle_cnt),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  flags;   // {done, pass, fail, timeout}
    logic [31:0] code;
    logic [31:0] cyc;
    logic [31:0] wrs;
  } vec_t;

  vec_t vt [16];

  function automatic logic [99:0] pack(input logic [3:0] f, input logic [31:0] c,
                                       input logic [31:0] y, input logic [31:0] w);
    return {f, c, y, w};
  endfunction

  function automatic logic [99:0] observed();
    return pack({done, pass, fail, timeout}, fail_code, cycle_cnt, wr_cnt);
  endfunction

  task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got flags=%b code=%0h cyc=%0d wr=%0d, want flags=%b code=%0h cyc=%0d wr=%0d",
               name, act[99:96], act[95:64], act[63:32], act[31:0],
               exp[99:96], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  // Drive one cycle of inputs, take the edge, and settle before sampling.
  task automatic step(input logic r, input logic we, input logic [4:0] a, input logic [31:0] d);
    rst = r; wb_we = we; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;

    //        name            rst  we   addr   data          flags    code   cyc  wr
    vt[0]  = '{"reset",        1, 0,  5'd0,  32'd0,        4'b0000, 32'd0, 0, 0};
    vt[1]  = '{"wr_x27_1",     0, 1,  5'd27, 32'd1,        4'b0000, 32'd0, 1, 1};
    vt[2]  = '{"wr_x0",        0, 1,  5'd0,  32'hFFFFFFFF, 4'b0000, 32'd0, 2, 1};
    vt[3]  = '{"wr_x26_0",     0, 1,  5'd26, 32'd0,        4'b0000, 32'd0, 3, 2};
    vt[4]  = '{"done_pass",    0, 1,  5'd26, 32'd1,        4'b1100, 32'd0, 4, 3};
    vt[5]  = '{"wr_in_pass",   0, 1,  5'd5,  32'd7,        4'b1100, 32'd0, 4, 3};
    vt[6]  = '{"rst_drop_wr",  1, 1,  5'd27, 32'd1,        4'b0000, 32'd0, 0, 0};
    vt[7]  = '{"wr_x3_5",      0, 1,  5'd3,  32'd5,        4'b0000, 32'd0, 1, 1};
    vt[8]  = '{"wr_x27_0",     0, 1,  5'd27, 32'd0,        4'b0000, 32'd0, 2, 2};
    vt[9]  = '{"done_fail",    0, 1,  5'd26, 32'd1,        4'b1010, 32'd5, 3, 3};
    vt[10] = '{"wr_in_fail",   0, 1,  5'd3,  32'd9,        4'b1010, 32'd5, 3, 3};
    vt[11] = '{"reset2",       1, 0,  5'd0,  32'd0,        4'b0000, 32'd0, 0, 0};
    vt[12] = '{"wr_x27_1b",    0, 1,  5'd27, 32'd1,        4'b0000, 32'd0, 1, 1};
    vt[13] = '{"rst_mid",      1, 0,  5'd0,  32'd0,        4'b0000, 32'd0, 0, 0};
    vt[14] = '{"done_after_r", 0, 1,  5'd26, 32'd1,        4'b1010, 32'd0, 1, 1};
    vt[15] = '{"rst_term",     1, 0,  5'd0,  32'd0,        4'b0000, 32'd0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(vt[i].rst, vt[i].we, vt[i].addr, vt[i].data);
      check(vt[i].name, observed(), pack(vt[i].flags, vt[i].code, vt[i].cyc, vt[i].wrs));
    end

    // Pass with the done write landing on the tenth RUN cycle.
    step(1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd27, 32'd1);
    idle(8);
    check("pass_pre", observed(), pack(4'b0000, 32'd0, 32'd9, 32'd1));
    step(1'b0, 1'b1, 5'd26, 32'd1);
    check("pass_c10", observed(), pack(4'b1100, 32'd0, 32'd10, 32'd2));
    idle(3);
    check("pass_hold", observed(), pack(4'b1100, 32'd0, 32'd10, 32'd2));

    // Watchdog: no done write, expiry after exactly TO RUN cycles.
    step(1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd3, 32'd7);
    idle(TO - 2);
    check("to_pre", observed(), pack(4'b0000, 32'd0, 32'(TO - 1), 32'd1));
    idle(1);
    check("to_hit", observed(), pack(4'b1001, 32'd7, 32'(TO), 32'd1));
    idle(2);
    check("to_hold", observed(), pack(4'b1001, 32'd7, 32'(TO), 32'd1));

    // Race: done write on the same edge the watchdog would fire.
    step(1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd27, 32'd1);
    idle(TO - 2);
    check("race_pre", observed(), pack(4'b0000, 32'd0, 32'(TO - 1), 32'd1));
    step(1'b0, 1'b1, 5'd26, 32'd1);
    check("race_pass", observed(), pack(4'b1100, 32'd0, 32'(TO), 32'd2));

    // Zero-data done writes and x0 traffic must not end the test.
    step(1'b1, 1'b0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 5'd0, 32'd1);
    step(1'b0, 1'b1, 5'd26, 32'd0);
    step(1'b0, 1'b1, 5'd0, 32'h8000_0000);
    check("filter", observed(), pack(4'b0000, 32'd0, 32'd3, 32'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
